// File: rtl/comp_serial_if.sv
// Handshake and operand/result bundle for the serial magnitude comparator.
// The master drives start/a/b; the slave returns busy/done and the gt/eq/lt flags.
interface comp_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (output start, a, b, input busy, done, gt, eq, lt);
  modport slave  (input start, a, b, output busy, done, gt, eq, lt);
endinterface

// File: rtl/comp_serial_ctrl.sv
// Serial MSB-first magnitude compare, one 2-bit digit per clock, with early exit.
// Define COMP_SERIAL_SIGNED_EN to treat the operands as two's complement.
module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_serial_if.slave  bus
);
  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Same equations as the 2-bit dataflow comparator slice: {gt, eq, lt}.
  function automatic logic [2:0] cmp2(input logic [1:0] x, input logic [1:0] y);
    logic g, e, l;
    g = (x[1] & ~y[1]) | (~(x[1] ^ y[1]) & x[0] & ~y[0]);
    e = ~(x[1] ^ y[1]) & ~(x[0] ^ y[0]);
    l = (~x[1] & y[1]) | (~(x[1] ^ y[1]) & ~x[0] & y[0]);
    return {g, e, l};
  endfunction

  state_t           state_r, state_s;
  logic [IW-1:0]    idx_r, idx_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             gt_r, gt_s;
  logic             eq_r, eq_s;
  logic             lt_r, lt_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [2:0]       digit_s;
  logic [WIDTH-1:0] a_in_s;
  logic [WIDTH-1:0] b_in_s;

`ifdef COMP_SERIAL_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_in_s = bus.a ^ SIGN_FLIP;
  assign b_in_s = bus.b ^ SIGN_FLIP;
`else
  assign a_in_s = bus.a;
  assign b_in_s = bus.b;
`endif

  assign digit_s = cmp2(a_r[{idx_r, 1'b0} +: 2], b_r[{idx_r, 1'b0} +: 2]);

  // Next-state, operand latch, digit walk and result flags.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    a_s     = a_r;
    b_s     = b_r;
    gt_s    = gt_r;
    eq_s    = eq_r;
    lt_s    = lt_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          a_s     = a_in_s;
          b_s     = b_in_s;
          idx_s   = IDX_TOP;
          gt_s    = 1'b0;
          eq_s    = 1'b0;
          lt_s    = 1'b0;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (digit_s[2]) begin
          gt_s    = 1'b1;
          state_s = DONE;
        end else if (digit_s[0]) begin
          lt_s    = 1'b1;
          state_s = DONE;
        end else if (idx_r == {IW{1'b0}}) begin
          eq_s    = 1'b1;
          state_s = DONE;
        end else begin
          idx_s   = idx_r - {{(IW-1){1'b0}}, 1'b1};
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // State and datapath registers; busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      idx_r   <= {IW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      gt_r    <= 1'b0;
      eq_r    <= 1'b0;
      lt_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      a_r     <= a_s;
      b_r     <= b_s;
      gt_r    <= gt_s;
      eq_r    <= eq_s;
      lt_r    <= lt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.gt   = gt_r;
  assign bus.eq   = eq_r;
  assign bus.lt   = lt_r;
endmodule

// File: tb/tb_comp_serial_ctrl.sv
// Directed self-checking bench for comp_serial_ctrl (WIDTH=8), both signedness builds.
module tb_comp_serial_ctrl;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  comp_serial_if #(.WIDTH(WIDTH)) bus ();

  comp_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one start at the next edge, then follow the run until done.
  // cyc = negedges after the accepting edge until done is seen (expect N+1),
  // nbusy = cycles busy was observed high, seen = done observed within budget.
  task automatic run_cmp(input logic [7:0] av, input logic [7:0] bv,
                         output int cyc, output int nbusy, output bit seen);
    cyc   = 0;
    nbusy = 0;
    seen  = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.done === 1'b1) begin
        cyc  = k;
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_outputs got=%b want=00000",
               {bus.busy, bus.done, bus.gt, bus.eq, bus.lt});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_gt_early();
    int cyc, nb;
    bit seen;
    run_cmp(8'hB4, 8'h4B, cyc, nb, seen);
    tests++;
    if (!seen || cyc != 2 || nb != 1) begin
      fails++;
      $display("FAIL gt_latency seen=%0d cyc=%0d busy=%0d want cyc=2 busy=1", seen, cyc, nb);
    end
    tests++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b100) begin
      fails++;
      $display("FAIL gt_result got=%b want=100", {bus.gt, bus.eq, bus.lt});
    end
    @(negedge clk);
    tests++;
    if ({bus.done, bus.busy, bus.gt, bus.eq, bus.lt} !== 5'b00100) begin
      fails++;
      $display("FAIL gt_hold got=%b want=00100", {bus.done, bus.busy, bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_eq_full();
    int cyc, nb;
    bit seen;
    run_cmp(8'h5A, 8'h5A, cyc, nb, seen);
    tests++;
    if (!seen || cyc != 5 || nb != 4) begin
      fails++;
      $display("FAIL eq_latency seen=%0d cyc=%0d busy=%0d want cyc=5 busy=4", seen, cyc, nb);
    end
    tests++;
    if ({bus.gt, bus.eq, bus.lt} !== 3'b010) begin
      fails++;
      $display("FAIL eq_result got=%b want=010", {bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_back_to_back();
    int cyc, nb;
    bit seen;
    run_cmp(8'h12, 8'h13, cyc, nb, seen);
    tests++;
    if (!seen || cyc != 5 || nb != 4 || {bus.gt, bus.eq, bus.lt} !== 3'b001) begin
      fails++;
      $display("FAIL b2b_first seen=%0d cyc=%0d busy=%0d res=%b want 5/4/001",
               seen, cyc, nb, {bus.gt, bus.eq, bus.lt});
    end
    // Start during the DONE cycle must be accepted.
    bus.start = 1'b1;
    bus.a     = 8'hC0;
    bus.b     = 8'h40;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    tests++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b10000) begin
      fails++;
      $display("FAIL b2b_accept got=%b want=10000", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt});
    end
    @(negedge clk);
    tests++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b01100) begin
      fails++;
      $display("FAIL b2b_second got=%b want=01100", {bus.busy, bus.done, bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_start_while_busy();
    int pulses;
    int cyc;
    pulses = 0;
    cyc    = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h33;
    @(posedge clk);
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    for (int k = 1; k <= 12; k++) begin
      if (bus.done === 1'b1) begin
        pulses++;
        if (cyc == 0) cyc = k;
        bus.start = 1'b0;
      end else if (bus.busy === 1'b1) begin
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (k == 5) begin
        tests++;
        if ({bus.gt, bus.eq, bus.lt} !== 3'b010) begin
          fails++;
          $display("FAIL busy_start_result got=%b want=010", {bus.gt, bus.eq, bus.lt});
        end
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    tests++;
    if (pulses != 1 || cyc != 5) begin
      fails++;
      $display("FAIL busy_start_pulses got=%0d at=%0d want=1 at=5", pulses, cyc);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, nb, pulses;
    bit seen;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.busy, bus.done, bus.gt, bus.eq, bus.lt} !== 5'b00000) begin
      fails++;
      $display("FAIL reset_mid_outputs got=%b want=00000",
               {bus.busy, bus.done, bus.gt, bus.eq, bus.lt});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
      if (k == 1) rst_n = 1'b1;
    end
    tests++;
    if (pulses != 0) begin
      fails++;
      $display("FAIL reset_mid_done got=%0d want=0", pulses);
    end
    run_cmp(8'h01, 8'h02, cyc, nb, seen);
    tests++;
    if (!seen || cyc != 5 || nb != 4 || {bus.gt, bus.eq, bus.lt} !== 3'b001) begin
      fails++;
      $display("FAIL reset_mid_fresh seen=%0d cyc=%0d busy=%0d res=%b want 5/4/001",
               seen, cyc, nb, {bus.gt, bus.eq, bus.lt});
    end
  endtask

  task automatic test_signedness();
    int cyc, nb;
    bit seen;
    logic [2:0] want;
`ifdef COMP_SERIAL_SIGNED_EN
    want = 3'b001;
`else
    want = 3'b100;
`endif
    run_cmp(8'h80, 8'h01, cyc, nb, seen);
    tests++;
    if (!seen || cyc != 2 || nb != 1 || {bus.gt, bus.eq, bus.lt} !== want) begin
      fails++;
      $display("FAIL signedness seen=%0d cyc=%0d busy=%0d res=%b want 2/1/%b",
               seen, cyc, nb, {bus.gt, bus.eq, bus.lt}, want);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_gt_early();
    test_eq_full();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid();
    test_signedness();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/comp_serial_ctrl.md
Name: comp_serial_ctrl

Overview:
- Sequencing controller for a multi-word magnitude compare built from the team's 2-bit dataflow comparator slice (gt/eq/lt outputs).
- Latches two WIDTH-bit operands on a start handshake and walks them MSB-first, one 2-bit digit per clock, through a single 2-bit compare stage.
- Terminates early on the first unequal digit and reports registered gt/eq/lt with a one-cycle done pulse.
- Used wherever wide compares are needed but area for a full-width comparator is not justified.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 2. Digit count is D = WIDTH/2.

Ports:
- clk    input   1      system clock, rising edge
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request a compare. Sampled only when not busy.
- a      input   WIDTH  operand A, sampled with an accepted start
- b      input   WIDTH  operand B, sampled with an accepted start
- busy   output  1      compare in progress (state RUN)
- done   output  1      one-cycle pulse: result valid
- gt     output  1      A > B, registered
- eq     output  1      A == B, registered
- lt     output  1      A < B, registered

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-low.
  - While rst_n=0: state=IDLE, busy=0, done=0, gt=eq=lt=0, digit index=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge is accepted.
  - On accept: latch a and b, set index=D-1, clear gt/eq/lt to 0, go to RUN.
- RUN (busy=1):
  - Each edge compares latched digit a_r[2*idx+1:2*idx] against b_r[2*idx+1:2*idx] using the 2-bit comparator equations: gt = (a1>b1) | (a1==b1 & a0>b0); eq and lt formed likewise.
  - Digit gt: set gt=1, go to DONE.
  - Digit lt: set lt=1, go to DONE.
  - Digit eq and idx=0: set eq=1, go to DONE.
  - Digit eq and idx>0: idx <= idx-1, stay in RUN.
- DONE:
  - done=1 for exactly this one cycle, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back compares). Otherwise go to IDLE.
- Latency:
  - With the start accepted at edge E0, done is high in the cycle after edge E0+N.
  - N = number of digits examined, 1..D.
  - Throughput for back-to-back compares: one compare every N+1 cycles.
- Result outputs:
  - gt/eq/lt are one-hot when done=1.
  - They hold their value after done until the next accepted start clears them.
- start while busy=1: ignored. Operands are not re-sampled and the compare in flight is unaffected.
- a/b changing after accept: no effect, because operands are latched.
- Reset mid-operation: immediate return to the reset values above. No done pulse is generated.
- WIDTH=2: D=1, so every compare completes with N=1.
- Index register width: clog2(D), minimum 1 bit.

Optional Feature:
- Macro: COMP_SERIAL_SIGNED_EN.
- Defined:
  - Operands are two's complement.
  - At latch time bit WIDTH-1 of both a and b is inverted, mapping signed order onto unsigned order.
  - The digit walk is otherwise unchanged.
- Undefined: operands are unsigned and no inversion logic is present.
- Port list, latency and handshake are identical in both builds.

Test Plan:
- WIDTH=8, a=8'hB4, b=8'h4B, start pulse: top digit 10 vs 01 → gt=1, eq=lt=0, N=1; done high one cycle after edge E0+1; busy high for 1 cycle.
- a=8'h5A, b=8'h5A: all 4 digits equal → eq=1, N=4; done after edge E0+4; busy high 4 cycles.
- a=8'h12, b=8'h13: digits 3..1 equal, digit 0 10<11 → lt=1, N=4. Next, issue start=1 in the DONE cycle with a=8'hC0, b=8'h40 → accepted, gt=1 with N=1.
- start re-asserted on every cycle while busy with a=8'hFF, b=8'h00 applied mid-run, original compare a=8'h33, b=8'h33 → extra starts ignored; eq=1 after 4 digits; exactly one done pulse.
- rst_n driven low during RUN at idx=2 (a=8'h00, b=8'h00): all outputs 0 immediately; no done pulse; after release, a fresh start with a=8'h01, b=8'h02 → lt=1, N=4.
- a=8'h80, b=8'h01: with COMP_SERIAL_SIGNED_EN → lt=1 (-128 < 1); without it → gt=1 (128 > 1); N=1 in both builds.
